pe_qmac: RTL and testbench
==========================

Name: pe_qmac

Overview:
- Parametrised systolic processing element for the hybrid SNN/ANN accelerator array; next generation of the single-cycle weight-stationary MAC PE.
- Activation flows left to right (in0→out0) and partial sums flow top to bottom (in1→out1).
- Adds runtime weight loading, signed quantised arithmetic, an internal output-channel phase counter, valid tagging, a stall input and overflow handling.
- Instantiated in a grid by the array wrapper; all neighbours share clk, rst, en, transit and oc_step.

Parameters:
ACT_W, 8, activation width (signed)
W_W, 8, stored weight width (unsigned code)
ACC_W, 32, partial-sum width (signed)
OUT_CHANNELS, 4, number of weights held, one per output channel; ≥2
W_ZPT, 0, weight zero-point subtracted from the stored code
W_SCALE, 1, integer weight scale multiplier (signed, ≥1)
W_SHIFT, 0, arithmetic right shift applied to the scaled product

Ports:
clk  in  1  clock
rst  in  1  synchronous active-low reset
transit  in  1  layer-transition clear, active high
en  in  1  advance enable; 0 = stall, all registers hold
oc_step  in  1  advance output-channel phase (honoured only when en=1)
wr_en  in  1  weight write strobe
wr_addr  in  $clog2(OUT_CHANNELS)  weight slot
wr_data  in  W_W  weight code
in0  in  ACT_W  activation from left (signed)
in0_valid  in  1  in0 qualifier
in1  in  ACC_W  partial sum from above (signed)
in1_valid  in  1  in1 qualifier
out0  out  ACT_W  activation to right
out0_valid  out  1
out1  out  ACC_W  partial sum downward
out1_valid  out  1
phase  out  $clog2(OUT_CHANNELS)  current output-channel index
ovf  out  1  sticky overflow flag

Behaviour:
- Priority order: rst=0 > transit=1 > en=1 > hold.
- Reset (rst=0 at a clk edge): out0, out1, out0_valid, out1_valid, phase and ovf go to 0. The weight memory is not reset.
- Transit: same clears as reset, in one cycle. Weight memory is retained.
- Stall (en=0): every output register and phase hold their values. Weight writes still occur.
- Latency: one cycle from in* to out* for both paths.
- Activation path: out0 ← in0; out0_valid ← in0_valid.
- Operand selection:
  - a = in0 if in0_valid else 0.
  - p = in1 if in1_valid else 0.
  - out1_valid ← in0_valid | in1_valid.
- Arithmetic, full-precision signed, no intermediate truncation:
  - wq = $signed({1'b0, W[phase]}) − W_ZPT.
  - prod = (wq × a × W_SCALE) >>> W_SHIFT; the shift floors toward −inf.
  - sum = p + prod, computed at ACC_W+1 bits or wider.
  - out1 ← sum, with overflow handling per the Optional Feature.
- Phase counter:
  - When en=1 and oc_step=1, phase increments and wraps from OUT_CHANNELS−1 to 0.
  - The MAC in that same cycle uses the pre-increment phase.
- Weight write: W[wr_addr] ← wr_data at the clk edge.
  - Read-before-write: if wr_addr equals phase in the same cycle, the MAC uses the old weight.
  - Writes are ignored while rst=0.
  - Writes are accepted during transit.
  - wr_addr ≥ OUT_CHANNELS is ignored.
- Idle cycle: when in0_valid=0 and in1_valid=0, out1=0 and out1_valid=0.

Optional Feature:
- Macro: PE_QMAC_SAT_EN
- Defined:
  - sum is clamped to [−2^(ACC_W−1), 2^(ACC_W−1)−1].
  - ovf is set on any cycle with en=1 whose sum lies outside that range.
  - ovf stays set until rst or transit.
- Undefined:
  - out1 takes sum[ACC_W−1:0] (two's-complement wrap).
  - ovf is tied to 0.

Test Plan:
- Weight load and basic MAC: load W={3, 0xFE, 5, 7}; phase=0; in0=10, in1=100, both valid → next cycle out1=130, out0=10, both valids=1.
- Phase step with zero-point: instance with W_ZPT=0; W[1]=0xFE is code 254 → pulse oc_step, then in0=10, in1=0 → out1=2540; after 4 oc_step pulses phase returns to 0.
- Quantisation: instance with W_ZPT=128, W_SCALE=3, W_SHIFT=2 and W[0]=132; in0=−5, in1=0 → out1=−15. With in0=−1: (−12)>>>2 → out1=−3.
- Saturation: ACC_W=16, W[0]=7, in0=10, in1=32760.
  - PE_QMAC_SAT_EN defined → out1=32767, ovf=1.
  - Undefined → out1=−32706, ovf=0.
- Stall, transit and reset:
  - en=0 for 3 cycles with toggling inputs → outputs frozen.
  - transit=1 → out0=out1=0, valids=0, phase=0, ovf=0; weights still give correct products afterwards.
  - rst=0 during en=1 → same clears, with rst winning over transit.
- Write/read collision and partial valids:
  - wr_en with wr_addr=phase, wr_data=9, in the same cycle as in0=2 → out1 uses the old weight; the next cycle uses 9.
  - in0_valid=1, in1_valid=0, in1=500 → out1=W×in0 (500 ignored).
  - in0_valid=0, in1_valid=1 → out1=in1.

Source files
------------

// File: rtl/pe_qmac.sv
// Weight-stationary systolic MAC PE with runtime weight loading, quantised signed arithmetic and
// an output-channel phase counter. Define PE_QMAC_SAT_EN to saturate out1 and enable sticky ovf.
module pe_qmac #(
    parameter int unsigned ACT_W        = 8,
    parameter int unsigned W_W          = 8,
    parameter int unsigned ACC_W        = 32,
    parameter int unsigned OUT_CHANNELS = 4,
    parameter int          W_ZPT        = 0,
    parameter int          W_SCALE      = 1,
    parameter int unsigned W_SHIFT      = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            transit,
    input  logic                            en,
    input  logic                            oc_step,
    input  logic                            wr_en,
    input  logic [$clog2(OUT_CHANNELS)-1:0] wr_addr,
    input  logic [W_W-1:0]                  wr_data,
    input  logic [ACT_W-1:0]                in0,
    input  logic                            in0_valid,
    input  logic [ACC_W-1:0]                in1,
    input  logic                            in1_valid,
    output logic [ACT_W-1:0]                out0,
    output logic                            out0_valid,
    output logic [ACC_W-1:0]                out1,
    output logic                            out1_valid,
    output logic [$clog2(OUT_CHANNELS)-1:0] phase,
    output logic                            ovf
);

    localparam int unsigned PH_W  = $clog2(OUT_CHANNELS);
    // Wide enough for (zero-pointed weight) x activation x 32-bit scale with no truncation.
    localparam int unsigned MUL_W = W_W + ACT_W + 66;
    localparam int unsigned SUM_W = ((MUL_W > ACC_W) ? MUL_W : ACC_W) + 1;

    logic [W_W-1:0]          w_mem [OUT_CHANNELS];
    logic [ACT_W-1:0]        out0_q;
    logic                    out0_valid_q;
    logic [ACC_W-1:0]        out1_q, out1_d;
    logic                    out1_valid_q;
    logic [PH_W-1:0]         phase_q, phase_d;
    logic signed [MUL_W-1:0] wq, a_ext, scale_ext, prod;
    logic signed [SUM_W-1:0] p_ext, sum;

    always_ff @(posedge clk) begin
        if (rst && wr_en && (32'(wr_addr) < OUT_CHANNELS)) begin
            w_mem[wr_addr] <= wr_data;
        end
    end

    // Weight read uses the pre-increment phase and the pre-write memory contents.
    always_comb begin
        wq        = MUL_W'($signed({1'b0, w_mem[phase_q]})) - MUL_W'(W_ZPT);
        a_ext     = in0_valid ? MUL_W'($signed(in0)) : '0;
        scale_ext = MUL_W'(W_SCALE);
        prod      = (wq * a_ext * scale_ext) >>> W_SHIFT;
        p_ext     = in1_valid ? SUM_W'($signed(in1)) : '0;
        sum       = p_ext + SUM_W'(prod);
        phase_d   = phase_q;
        if (oc_step) begin
            phase_d = (phase_q == PH_W'(OUT_CHANNELS - 1)) ? '0 : phase_q + 1'b1;
        end
    end

`ifdef PE_QMAC_SAT_EN
    localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'({(ACC_W - 1){1'b1}});
    localparam logic signed [SUM_W-1:0] SAT_MIN = ~SAT_MAX;

    logic ovf_q, ovf_now;

    always_comb begin
        ovf_now = 1'b0;
        out1_d  = sum[ACC_W-1:0];
        if (sum > SAT_MAX) begin
            ovf_now = 1'b1;
            out1_d  = SAT_MAX[ACC_W-1:0];
        end else if (sum < SAT_MIN) begin
            ovf_now = 1'b1;
            out1_d  = SAT_MIN[ACC_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || transit) begin
            ovf_q <= 1'b0;
        end else if (en) begin
            ovf_q <= ovf_q | ovf_now;
        end
    end

    assign ovf = ovf_q;
`else
    logic unused_sum_hi;

    always_comb begin
        out1_d = sum[ACC_W-1:0];
    end

    assign unused_sum_hi = ^sum[SUM_W-1:ACC_W];
    assign ovf           = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst || transit) begin
            out0_q       <= '0;
            out0_valid_q <= 1'b0;
            out1_q       <= '0;
            out1_valid_q <= 1'b0;
            phase_q      <= '0;
        end else if (en) begin
            out0_q       <= in0;
            out0_valid_q <= in0_valid;
            out1_q       <= out1_d;
            out1_valid_q <= in0_valid | in1_valid;
            phase_q      <= phase_d;
        end
    end

    assign out0       = out0_q;
    assign out0_valid = out0_valid_q;
    assign out1       = out1_q;
    assign out1_valid = out1_valid_q;
    assign phase      = phase_q;

endmodule

// File: tb/tb_pe_qmac.sv
// Directed bench for pe_qmac: a default instance, a quantised instance and a 16-bit accumulator
// instance share clock, control and activations; each has its own weight write port.
module tb_pe_qmac;

    logic        clk = 1'b0;
    logic        rst, transit, en, oc_step;
    logic        wr_en_a, wr_en_q, wr_en_s;
    logic [1:0]  wr_addr;
    logic [7:0]  wr_data_a, wr_data_q, wr_data_s;
    logic [7:0]  in0;
    logic        in0_valid;
    logic [31:0] in1;
    logic        in1_valid;

    logic [7:0]  out0_a, out0_q, out0_s;
    logic [31:0] out1_a, out1_q;
    logic [15:0] out1_s;
    logic        out0_valid_a, out0_valid_q, out0_valid_s;
    logic        out1_valid_a, out1_valid_q, out1_valid_s;
    logic [1:0]  phase_a, phase_q, phase_s;
    logic        ovf_a, ovf_q, ovf_s;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    pe_qmac u_main (
        .clk(clk), .rst(rst), .transit(transit), .en(en), .oc_step(oc_step),
        .wr_en(wr_en_a), .wr_addr(wr_addr), .wr_data(wr_data_a),
        .in0(in0), .in0_valid(in0_valid), .in1(in1), .in1_valid(in1_valid),
        .out0(out0_a), .out0_valid(out0_valid_a), .out1(out1_a), .out1_valid(out1_valid_a),
        .phase(phase_a), .ovf(ovf_a)
    );

    pe_qmac #(.W_ZPT(128), .W_SCALE(3), .W_SHIFT(2)) u_quant (
        .clk(clk), .rst(rst), .transit(transit), .en(en), .oc_step(oc_step),
        .wr_en(wr_en_q), .wr_addr(wr_addr), .wr_data(wr_data_q),
        .in0(in0), .in0_valid(in0_valid), .in1(in1), .in1_valid(in1_valid),
        .out0(out0_q), .out0_valid(out0_valid_q), .out1(out1_q), .out1_valid(out1_valid_q),
        .phase(phase_q), .ovf(ovf_q)
    );

    pe_qmac #(.ACC_W(16)) u_sat (
        .clk(clk), .rst(rst), .transit(transit), .en(en), .oc_step(oc_step),
        .wr_en(wr_en_s), .wr_addr(wr_addr), .wr_data(wr_data_s),
        .in0(in0), .in0_valid(in0_valid), .in1(in1[15:0]), .in1_valid(in1_valid),
        .out0(out0_s), .out0_valid(out0_valid_s), .out1(out1_s), .out1_valid(out1_valid_s),
        .phase(phase_s), .ovf(ovf_s)
    );

    typedef struct {
        int   in0;
        logic in0_v;
        int   in1;
        logic in1_v;
        logic oc;
        logic en;
        int   e_out0;
        logic e_v0;
        int   e_out1;
        logic e_v1;
        int   e_ph;
    } vec_t;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int a, input logic av, input int p, input logic pv, input logic oc);
        in0       = 8'(a);
        in0_valid = av;
        in1       = 32'(p);
        in1_valid = pv;
        oc_step   = oc;
    endtask

    vec_t       vecs[9];
    logic [7:0] wtab[4];
    int         e_sat_out1;
    logic       e_sat_ovf;

    initial begin
        // W = {3, 0xFE, 5, 7}, zero-point 0, scale 1: expected out1 = in1 + W[phase]*in0
        vecs[0] = '{10,   1'b1, 100,  1'b1, 1'b0, 1'b1, 10,   1'b1, 130,  1'b1, 0};
        vecs[1] = '{10,   1'b1, 0,    1'b0, 1'b1, 1'b1, 10,   1'b1, 30,   1'b1, 1};
        vecs[2] = '{10,   1'b1, 0,    1'b0, 1'b0, 1'b1, 10,   1'b1, 2540, 1'b1, 1};
        vecs[3] = '{-3,   1'b1, 1000, 1'b1, 1'b1, 1'b1, -3,   1'b1, 238,  1'b1, 2};
        vecs[4] = '{4,    1'b1, 500,  1'b0, 1'b1, 1'b1, 4,    1'b1, 20,   1'b1, 3};
        vecs[5] = '{-128, 1'b1, -5,   1'b1, 1'b1, 1'b1, -128, 1'b1, -901, 1'b1, 0};
        vecs[6] = '{55,   1'b0, 77,   1'b1, 1'b0, 1'b1, 55,   1'b0, 77,   1'b1, 0};
        vecs[7] = '{9,    1'b0, 1234, 1'b0, 1'b0, 1'b1, 9,    1'b0, 0,    1'b0, 0};
        vecs[8] = '{1,    1'b1, 1,    1'b1, 1'b1, 1'b0, 9,    1'b0, 0,    1'b0, 0};
        wtab[0] = 8'd3; wtab[1] = 8'hFE; wtab[2] = 8'd5; wtab[3] = 8'd7;

`ifdef PE_QMAC_SAT_EN
        e_sat_out1 = 32767;
        e_sat_ovf  = 1'b1;
`else
        e_sat_out1 = -32706;
        e_sat_ovf  = 1'b0;
`endif

        rst = 1'b0; transit = 1'b0; en = 1'b1;
        wr_en_a = 1'b0; wr_en_q = 1'b0; wr_en_s = 1'b0; wr_addr = '0;
        wr_data_a = '0; wr_data_q = '0; wr_data_s = '0;
        drive(0, 1'b0, 0, 1'b0, 1'b0);
        step();
        step();
        chk("rst.out0", out0_a, 0);
        chk("rst.out1", out1_a, 0);
        chk("rst.valids", {out0_valid_a, out1_valid_a}, 0);
        chk("rst.phase", phase_a, 0);
        chk("rst.ovf", {ovf_a, ovf_s}, 0);

        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_addr   = 2'(i);
            wr_data_a = wtab[i];
            wr_data_q = 8'd132;
            wr_data_s = 8'd7;
            {wr_en_a, wr_en_q, wr_en_s} = 3'b111;
            step();
        end
        {wr_en_a, wr_en_q, wr_en_s} = 3'b000;

        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].in0, vecs[i].in0_v, vecs[i].in1, vecs[i].in1_v, vecs[i].oc);
            en = vecs[i].en;
            step();
            chk($sformatf("v%0d.out0", i), $signed(out0_a), vecs[i].e_out0);
            chk($sformatf("v%0d.out0_valid", i), out0_valid_a, vecs[i].e_v0);
            chk($sformatf("v%0d.out1", i), $signed(out1_a), vecs[i].e_out1);
            chk($sformatf("v%0d.out1_valid", i), out1_valid_a, vecs[i].e_v1);
            chk($sformatf("v%0d.phase", i), phase_a, vecs[i].e_ph);
        end

        // Stall: outputs and phase freeze while inputs toggle.
        en = 1'b1;
        drive(10, 1'b1, 100, 1'b1, 1'b0);
        step();
        chk("stall.pre", $signed(out1_a), 130);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(20 + i, i[0], i * 7, 1'b1, 1'b1);
            step();
            chk($sformatf("stall%0d.out0", i), out0_a, 10);
            chk($sformatf("stall%0d.out1", i), $signed(out1_a), 130);
            chk($sformatf("stall%0d.phase", i), phase_a, 0);
        end
        en = 1'b1;

        // Transit clears state but keeps weights.
        drive(10, 1'b1, 100, 1'b1, 1'b1);
        step();
        step();
        chk("pretransit.phase", phase_a, 2);
        transit = 1'b1;
        step();
        transit = 1'b0;
        chk("transit.out0", out0_a, 0);
        chk("transit.out1", out1_a, 0);
        chk("transit.valids", {out0_valid_a, out1_valid_a}, 0);
        chk("transit.phase", phase_a, 0);
        drive(2, 1'b1, 0, 1'b0, 1'b0);
        step();
        chk("transit.keepw", $signed(out1_a), 6);

        // Quantised instance: wq = 132-128 = 4, scale 3, shift 2.
        drive(-5, 1'b1, 0, 1'b0, 1'b0);
        step();
        chk("quant.m5", $signed(out1_q), -15);
        drive(-1, 1'b1, 0, 1'b0, 1'b0);
        step();
        chk("quant.m1", $signed(out1_q), -3);

        // 16-bit accumulator: 32760 + 7*10 = 32830 exceeds range.
        drive(10, 1'b1, 32760, 1'b1, 1'b0);
        step();
        chk("sat.out1", $signed(out1_s), e_sat_out1);
        chk("sat.ovf", ovf_s, e_sat_ovf);
        chk("sat.main", $signed(out1_a), 32790);
        drive(0, 1'b0, 0, 1'b0, 1'b0);
        step();
        chk("sat.sticky", ovf_s, e_sat_ovf);
        chk("sat.idle", out1_s, 0);
        transit = 1'b1;
        step();
        transit = 1'b0;
        chk("sat.clear", ovf_s, 0);

        // Write to the active slot: MAC sees old weight this cycle, new one after.
        wr_en_a = 1'b1; wr_addr = 2'd0; wr_data_a = 8'd9;
        drive(2, 1'b1, 0, 1'b0, 1'b0);
        step();
        wr_en_a = 1'b0;
        chk("coll.old", $signed(out1_a), 6);
        step();
        chk("coll.new", $signed(out1_a), 18);

        // Reset wins over transit and blocks weight writes.
        rst = 1'b0; transit = 1'b1;
        wr_en_a = 1'b1; wr_addr = 2'd1; wr_data_a = 8'h11;
        drive(5, 1'b1, 1, 1'b1, 1'b1);
        step();
        chk("rst2.out0", out0_a, 0);
        chk("rst2.out1", out1_a, 0);
        chk("rst2.valids", {out0_valid_a, out1_valid_a}, 0);
        chk("rst2.phase", phase_a, 0);
        rst = 1'b1; transit = 1'b0; wr_en_a = 1'b0;
        drive(1, 1'b1, 0, 1'b0, 1'b1);
        step();
        chk("rst2.w0", $signed(out1_a), 9);
        chk("rst2.phase1", phase_a, 1);
        drive(1, 1'b1, 0, 1'b0, 1'b0);
        step();
        chk("rst2.w1kept", $signed(out1_a), 254);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
